// File: rtl/vga_text_addr_gen_if.sv
// Timing inputs and position-counter / font outputs of vga_text_addr_gen.
// i_scroll_row exists only when VGA_HW_SCROLL_EN is defined.
interface vga_text_addr_gen_if #(
  parameter int CHAR_W = 8,
  parameter int CHAR_H = 16
);
  localparam int FONT_W  = $clog2(CHAR_H);
  localparam int PHASE_W = $clog2(CHAR_W);

  logic               i_frame_start;
  logic               i_line_start;
  logic               i_de;
`ifdef VGA_HW_SCROLL_EN
  logic [4:0]         i_scroll_row;
`endif
  logic               o_ld_h;
  logic [11:0]        o_ld_data;
  logic               o_en_h;
  logic [FONT_W-1:0]  o_font_row;
  logic [PHASE_W-1:0] o_col_phase;

`ifdef VGA_HW_SCROLL_EN
  modport master (
    output i_frame_start, i_line_start, i_de, i_scroll_row,
    input  o_ld_h, o_ld_data, o_en_h, o_font_row, o_col_phase
  );
  modport slave (
    input  i_frame_start, i_line_start, i_de, i_scroll_row,
    output o_ld_h, o_ld_data, o_en_h, o_font_row, o_col_phase
  );
`else
  modport master (
    output i_frame_start, i_line_start, i_de,
    input  o_ld_h, o_ld_data, o_en_h, o_font_row, o_col_phase
  );
  modport slave (
    input  i_frame_start, i_line_start, i_de,
    output o_ld_h, o_ld_data, o_en_h, o_font_row, o_col_phase
  );
`endif
endinterface

// File: rtl/vga_text_addr_gen.sv
// Text-mode address sequencer: row base reload per scanline, one increment per cell.
// Optional hardware scroll (start row sampled on frame start) under VGA_HW_SCROLL_EN.
module vga_text_addr_gen #(
  parameter int COLS       = 80,
  parameter int ROWS       = 25,
  parameter int CHAR_W     = 8,
  parameter int CHAR_H     = 16,
  parameter int START_ADDR = 0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  vga_text_addr_gen_if.slave bus
);
  localparam int FONT_W  = $clog2(CHAR_H);
  localparam int PHASE_W = $clog2(CHAR_W);
  localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CELLS   = COLS * ROWS;

  localparam logic [11:0]        START_BASE = 12'(START_ADDR);
  localparam logic [FONT_W-1:0]  FONT_LAST  = FONT_W'(CHAR_H - 1);
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(CHAR_W - 1);
  localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(ROWS - 1);

  logic [11:0]        row_base_q, row_base_d;
  logic [11:0]        start_base_q, start_base_d;
  logic [ROW_W-1:0]   row_idx_q, row_idx_d;
  logic               first_line_q, first_line_d;
  logic [PHASE_W-1:0] pix_ctr_q, pix_ctr_d;
  logic               ld_h_q, ld_h_d;
  logic [11:0]        ld_data_q, ld_data_d;
  logic               en_h_q, en_h_d;
  logic [FONT_W-1:0]  font_row_q, font_row_d;

  logic [11:0] frame_base;
  logic [12:0] adv_sum;
  logic [11:0] row_next;

`ifdef VGA_HW_SCROLL_EN
  // Out-of-range scroll rows fall back to the fixed start address.
  always_comb begin
    if (int'(bus.i_scroll_row) < ROWS) begin
      frame_base = 12'(int'(bus.i_scroll_row) * COLS);
    end else begin
      frame_base = START_BASE;
    end
  end
`else
  assign frame_base = START_BASE;
`endif

  // One extra bit so the sum cannot overflow before wrapping back into the buffer.
  assign adv_sum  = {1'b0, row_base_q} + 13'(COLS);
  assign row_next = 12'((adv_sum >= 13'(CELLS)) ? (adv_sum - 13'(CELLS)) : adv_sum);

  always_comb begin
    row_base_d   = row_base_q;
    start_base_d = start_base_q;
    row_idx_d    = row_idx_q;
    first_line_d = first_line_q;
    pix_ctr_d    = pix_ctr_q;
    ld_h_d       = 1'b0;
    ld_data_d    = ld_data_q;
    en_h_d       = 1'b0;
    font_row_d   = font_row_q;

    if (bus.i_frame_start) begin
      row_idx_d    = '0;
      font_row_d   = '0;
      first_line_d = 1'b1;
      start_base_d = frame_base;
      row_base_d   = frame_base;
      // A coincident line start is the first line of the new frame.
      if (bus.i_line_start) begin
        ld_h_d       = 1'b1;
        ld_data_d    = frame_base;
        first_line_d = 1'b0;
        pix_ctr_d    = '0;
      end
    end else if (bus.i_line_start) begin
      ld_h_d    = 1'b1;
      pix_ctr_d = '0;
      if (first_line_q) begin
        ld_data_d    = row_base_q;
        font_row_d   = '0;
        first_line_d = 1'b0;
      end else if (font_row_q != FONT_LAST) begin
        font_row_d = font_row_q + 1'b1;
        ld_data_d  = row_base_q;
      end else begin
        font_row_d = '0;
        if (row_idx_q != ROW_LAST) begin
          row_idx_d  = row_idx_q + 1'b1;
          row_base_d = row_next;
          ld_data_d  = row_next;
        end else begin
          row_idx_d  = '0;
          row_base_d = start_base_q;
          ld_data_d  = start_base_q;
        end
      end
    end

    if (!bus.i_line_start && bus.i_de) begin
      pix_ctr_d = pix_ctr_q + 1'b1;
      en_h_d    = (pix_ctr_q == PHASE_LAST);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      row_base_q   <= START_BASE;
      start_base_q <= START_BASE;
      row_idx_q    <= '0;
      first_line_q <= 1'b1;
      pix_ctr_q    <= '0;
      ld_h_q       <= 1'b0;
      ld_data_q    <= '0;
      en_h_q       <= 1'b0;
      font_row_q   <= '0;
    end else begin
      row_base_q   <= row_base_d;
      start_base_q <= start_base_d;
      row_idx_q    <= row_idx_d;
      first_line_q <= first_line_d;
      pix_ctr_q    <= pix_ctr_d;
      ld_h_q       <= ld_h_d;
      ld_data_q    <= ld_data_d;
      en_h_q       <= en_h_d;
      font_row_q   <= font_row_d;
    end
  end

  assign bus.o_ld_h      = ld_h_q;
  assign bus.o_ld_data   = ld_data_q;
  assign bus.o_en_h      = en_h_q;
  assign bus.o_font_row  = font_row_q;
  assign bus.o_col_phase = pix_ctr_q;

endmodule

// File: tb/tb_vga_text_addr_gen.sv
// Randomized bench for vga_text_addr_gen against a line/pixel-count reference model.
module tb_vga_text_addr_gen;
  localparam int COLS  = 80;
  localparam int ROWS  = 25;
  localparam int CW    = 8;
  localparam int CH    = 16;
  localparam int START = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_text_addr_gen_if #(.CHAR_W(CW), .CHAR_H(CH)) bus ();

  vga_text_addr_gen #(
    .COLS(COLS), .ROWS(ROWS), .CHAR_W(CW), .CHAR_H(CH), .START_ADDR(START)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the load address follows from how many lines have been
  // started since the frame began; the phase from how many pixels since the line began.
  int m_line = 0, m_start = START, m_de_cnt = 0, e_ld_data = 0, e_font = 0;
  bit e_ld_h = 0, e_en = 0, m_valid = 0;

  initial forever begin
    @(posedge clk);
    m_valid = 1;
    if (rst) begin
      m_line = 0; m_start = START; m_de_cnt = 0;
      e_ld_h = 0; e_en = 0; e_ld_data = 0; e_font = 0;
    end else begin
      e_ld_h = 0;
      e_en   = 0;
      if (bus.i_frame_start) begin
`ifdef VGA_HW_SCROLL_EN
        m_start = (int'(bus.i_scroll_row) < ROWS) ? int'(bus.i_scroll_row) * COLS : START;
`else
        m_start = START;
`endif
        m_line = 0;
        e_font = 0;
      end
      if (bus.i_line_start) begin
        e_ld_h    = 1;
        e_ld_data = (m_start + ((m_line / CH) % ROWS) * COLS) % (COLS * ROWS);
        e_font    = m_line % CH;
        m_line++;
        m_de_cnt  = 0;
      end else if (bus.i_de) begin
        e_en = ((m_de_cnt % CW) == CW - 1);
        m_de_cnt++;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("ld_h",      int'(bus.o_ld_h),      int'(e_ld_h));
      chk("ld_data",   int'(bus.o_ld_data),   e_ld_data);
      chk("en_h",      int'(bus.o_en_h),      int'(e_en));
      chk("font_row",  int'(bus.o_font_row),  e_font);
      chk("col_phase", int'(bus.o_col_phase), m_de_cnt % CW);
    end
  end

  task automatic frame_pulse();
    @(negedge clk);
    bus.i_frame_start = 1'b1;
    @(negedge clk);
    bus.i_frame_start = 1'b0;
  endtask

  task automatic run_line(input bit with_fs, input int npix, input bit rand_gaps,
                          output int ld_seen, output int font_seen,
                          output int en_cnt, output int first_en);
    int p;
    int i;
    @(negedge clk);
    bus.i_line_start  = 1'b1;
    bus.i_frame_start = with_fs;
    bus.i_de          = rand_gaps ? 1'($urandom_range(0, 1)) : 1'b0;
    @(negedge clk);
    bus.i_line_start  = 1'b0;
    bus.i_frame_start = 1'b0;
    chk("line_ld_h", int'(bus.o_ld_h), 1);
    ld_seen   = int'(bus.o_ld_data);
    font_seen = int'(bus.o_font_row);
    en_cnt    = 0;
    first_en  = -1;
    p = 0;
    i = 0;
    while (p < npix) begin
      bus.i_de = rand_gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (bus.i_de) p++;
      @(negedge clk);
      i++;
      if (bus.o_en_h) begin
        en_cnt++;
        if (first_en < 0) first_en = i;
      end
    end
    bus.i_de = 1'b0;
    repeat (3) begin
      @(negedge clk);
      i++;
      if (bus.o_en_h) begin
        en_cnt++;
        if (first_en < 0) first_en = i;
      end
    end
    $display("line: ld_data=%0d font_row=%0d pixels=%0d en_pulses=%0d", ld_seen, font_seen, npix, en_cnt);
  endtask

  int ld_v, font_v, en_v, fe_v;

  initial begin
    bus.i_frame_start = 1'b0;
    bus.i_line_start  = 1'b0;
    bus.i_de          = 1'b0;
`ifdef VGA_HW_SCROLL_EN
    bus.i_scroll_row  = 5'd0;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_ld_h",      int'(bus.o_ld_h),      0);
    chk("idle_ld_data",   int'(bus.o_ld_data),   0);
    chk("idle_en_h",      int'(bus.o_en_h),      0);
    chk("idle_font_row",  int'(bus.o_font_row),  0);
    chk("idle_col_phase", int'(bus.o_col_phase), 0);

    // Full-width line straight after reset.
    run_line(1'b0, COLS * CW, 1'b0, ld_v, font_v, en_v, fe_v);
    chk("first_ld_data", ld_v, 0);
    chk("first_font", font_v, 0);
    chk("full_line_en_count", en_v, 80);
    chk("first_en_delay", fe_v, 8);

    // One full frame including the extra line beyond ROWS*CH.
    frame_pulse();
    for (int ln = 1; ln <= 401; ln++) begin
      run_line(1'b0, $urandom_range(0, 24), 1'b1, ld_v, font_v, en_v, fe_v);
      if (ln <= 16) begin
        chk("row0_ld_data", ld_v, 0);
        chk("row0_font", font_v, ln - 1);
      end
      if (ln == 17) begin
        chk("line17_ld_data", ld_v, 80);
        chk("line17_font", font_v, 0);
      end
      if (ln == 400) begin
        chk("line400_ld_data", ld_v, 1920);
        chk("line400_font", font_v, 15);
      end
      if (ln == 401) begin
        chk("line401_ld_data", ld_v, 0);
        chk("line401_font", font_v, 0);
      end
    end

    // Frame start coincident with line start.
    run_line(1'b1, 10, 1'b1, ld_v, font_v, en_v, fe_v);
    chk("coincident_ld_data", ld_v, 0);
    chk("coincident_font", font_v, 0);

`ifdef VGA_HW_SCROLL_EN
    bus.i_scroll_row = 5'd24;
    frame_pulse();
    for (int ln = 1; ln <= 17; ln++) begin
      run_line(1'b0, $urandom_range(0, 16), 1'b1, ld_v, font_v, en_v, fe_v);
      if (ln == 1)  chk("scroll24_first", ld_v, 1920);
      if (ln == 17) chk("scroll24_wrap", ld_v, 0);
    end
    bus.i_scroll_row = 5'd30;
    frame_pulse();
    run_line(1'b0, 8, 1'b1, ld_v, font_v, en_v, fe_v);
    chk("scroll30_first", ld_v, 0);
`endif

    // Reset in the middle of a line after five character rows.
    frame_pulse();
    for (int ln = 0; ln < 5 * CH; ln++)
      run_line(1'b0, $urandom_range(0, 8), 1'b1, ld_v, font_v, en_v, fe_v);
    @(negedge clk);
    bus.i_line_start = 1'b1;
    @(negedge clk);
    bus.i_line_start = 1'b0;
    bus.i_de = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    bus.i_de = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ld_h",      int'(bus.o_ld_h),      0);
    chk("rst_ld_data",   int'(bus.o_ld_data),   0);
    chk("rst_en_h",      int'(bus.o_en_h),      0);
    chk("rst_font_row",  int'(bus.o_font_row),  0);
    chk("rst_col_phase", int'(bus.o_col_phase), 0);
    run_line(1'b0, 12, 1'b1, ld_v, font_v, en_v, fe_v);
    chk("post_rst_ld_data", ld_v, 0);
    chk("post_rst_font", font_v, 0);

    // Random mix of lines, frame starts and resets.
    for (int it = 0; it < 300; it++) begin
      int r;
      r = $urandom_range(0, 19);
`ifdef VGA_HW_SCROLL_EN
      bus.i_scroll_row = 5'($urandom_range(0, 31));
`endif
      if (r == 0) begin
        frame_pulse();
      end else if (r == 1) begin
        run_line(1'b1, $urandom_range(0, 24), 1'b1, ld_v, font_v, en_v, fe_v);
      end else if (r == 2) begin
        @(negedge clk);
        rst = 1'b1;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
      end else begin
        run_line(1'b0, $urandom_range(0, 24), 1'b1, ld_v, font_v, en_v, fe_v);
      end
    end

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
